// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_pkg
//  Description : Shared encodings for the program-counter sequencer:
//                next-PC source select codes, sequencer state encoding and
//                a small helper used to flag misaligned register targets.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    // Next-PC source select, as presented on the pc_src port.
    localparam logic [1:0] PC_SEQ = 2'b00;  // pc + 4
    localparam logic [1:0] PC_BR  = 2'b01;  // pc + 4 + branch offset
    localparam logic [1:0] PC_JMP = 2'b10;  // {pc+4 upper nibble, jump field}
    localparam logic [1:0] PC_REG = 2'b11;  // register target, word aligned

    // Sequencer state encoding.
    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_HALTED = 2'b10
    } seq_state_t;

    // A register-sourced target is misaligned when either of its two
    // low bits is set; the sequencer still forces those bits to zero.
    function automatic logic target_misaligned(input logic [31:0] target);
        return |target[1:0];
    endfunction

endpackage : pc_sequencer_pkg
`default_nettype wire

// File: rtl/next_pc_mux.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_mux
//  Description : Combinational next-PC target selection.
//  Ports       : pc_plus4      - sequential successor of the current PC
//                branch_offset - sign-extended, pre-scaled branch offset
//                jump_shifted  - 28-bit word-aligned jump field
//                reg_target    - register-sourced jump target
//                pc_src        - source select (PC_SEQ/PC_BR/PC_JMP/PC_REG)
//                next_pc       - selected next program counter
//  Revision    : 1.0 - initial release
// ============================================================================
module next_pc_mux
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] branch_offset,
    input  logic [27:0] jump_shifted,
    input  logic [31:0] reg_target,
    input  logic [1:0]  pc_src,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            PC_SEQ:  next_pc = pc_plus4;
            // Natural 32-bit wrap; no overflow detection is wanted.
            PC_BR:   next_pc = pc_plus4 + branch_offset;
            // Jumps stay inside the 256 MB region of the sequential PC.
            PC_JMP:  next_pc = {pc_plus4[31:28], jump_shifted};
            // Low bits are forced clear; misalignment is reported separately.
            PC_REG:  next_pc = {reg_target[31:2], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

endmodule : next_pc_mux
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter sequencer with a boot delay, fetch request
//                handshake, branch/jump/register target selection, halt
//                handling and a sticky misaligned-target flag.
//  Parameters  : RESET_PC    - PC value loaded on reset
//                BOOT_CYCLES - cycles spent in BOOT before the first fetch
//  Ports       : clk, rst (async, active-high)
//                jump_shifted, branch_offset, reg_target, pc_src - target inputs
//                stall, halt, imem_ready                         - control
//                pc, pc_plus4, imem_req, halted, misalign_err    - status
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] jump_shifted,
    input  logic [31:0] branch_offset,
    input  logic [31:0] reg_target,
    input  logic [1:0]  pc_src,
    input  logic        stall,
    input  logic        halt,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        imem_req,
    output logic        halted,
    output logic        misalign_err
);

    // The boot counter must be able to hold BOOT_CYCLES itself: the
    // sequencer leaves BOOT on the edge after the counter reaches it, so
    // BOOT_CYCLES=0 leaves on the very first edge.
    localparam int unsigned    CNT_W     = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES);

    seq_state_t        r_state;
    seq_state_t        w_state_next;
    logic [CNT_W-1:0]  r_boot_cnt;
    logic [CNT_W-1:0]  w_boot_cnt_next;
    logic [31:0]       r_pc;
    logic [31:0]       w_pc_plus4;
    logic [31:0]       w_next_pc;
    logic              w_accept;
    logic              w_imem_req;
    logic              w_halted;
    logic              r_misalign;

    assign w_pc_plus4   = r_pc + 32'd4;

    assign pc           = r_pc;
    assign pc_plus4     = w_pc_plus4;
    assign imem_req     = w_imem_req;
    assign halted       = w_halted;
    assign misalign_err = r_misalign;

    next_pc_mux u_next_pc_mux (
        .pc_plus4      (w_pc_plus4),
        .branch_offset (branch_offset),
        .jump_shifted  (jump_shifted),
        .reg_target    (reg_target),
        .pc_src        (pc_src),
        .next_pc       (w_next_pc)
    );

    // ------------------------------------------------------------------
    // Sequencer state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_boot_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_boot_cnt <= w_boot_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_boot_cnt_next = r_boot_cnt;
        w_imem_req      = 1'b0;
        w_accept        = 1'b0;
        w_halted        = 1'b0;

        case (r_state)
            ST_BOOT: begin
                if (r_boot_cnt == BOOT_LAST) begin
                    w_state_next = ST_FETCH;
                end else begin
                    w_boot_cnt_next = r_boot_cnt + CNT_W'(1);
                end
            end

            ST_FETCH: begin
                // Stall suppresses the request outright, so a halt
                // presented under stall can never be accepted.
                w_imem_req = ~stall;
                w_accept   = ~stall & imem_ready;
                if (w_accept && halt) begin
                    w_state_next = ST_HALTED;
                end
            end

            ST_HALTED: begin
                w_halted = 1'b1;
            end

            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC and sticky misalignment flag; both only move on an accept.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else if (w_accept) begin
            r_pc <= w_next_pc;
            if ((pc_src == PC_REG) && target_misaligned(reg_target)) begin
                r_misalign <= 1'b1;
            end
        end
    end

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer. A reference model
//                tracks edges since reset, the halted condition, the sticky
//                misalignment flag and the PC, computed from the target
//                selection rules with plain arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          BOOT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [27:0] jump_shifted;
    logic [31:0] branch_offset;
    logic [31:0] reg_target;
    logic [1:0]  pc_src;
    logic        stall;
    logic        halt;
    logic        imem_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic        halted;
    logic        misalign_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc;
    int          m_edges;
    bit          m_halted;
    bit          m_mis;

    pc_sequencer #(
        .RESET_PC    (RST_PC),
        .BOOT_CYCLES (BOOT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_shifted  (jump_shifted),
        .branch_offset (branch_offset),
        .reg_target    (reg_target),
        .pc_src        (pc_src),
        .stall         (stall),
        .halt          (halt),
        .imem_ready    (imem_ready),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .imem_req      (imem_req),
        .halted        (halted),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [1:0] src,
                                             input logic [31:0] br, input logic [27:0] jmp,
                                             input logic [31:0] tgt);
        logic [31:0] seq;
        seq = cur + 32'd4;
        case (src)
            2'd0:    return seq;
            2'd1:    return seq + br;
            2'd2:    return (seq & 32'hF000_0000) | {4'h0, jmp};
            default: return tgt & 32'hFFFF_FFFC;
        endcase
    endfunction

    // Fetching begins once BOOT+1 edges have passed since reset release.
    function automatic bit exp_req();
        return (m_edges > BOOT) && !m_halted && !stall;
    endfunction

    task automatic drive(input logic [1:0] src, input logic st, input logic rdy, input logic hl);
        pc_src     = src;
        stall      = st;
        imem_ready = rdy;
        halt       = hl;
    endtask

    // One clock edge; the model advances from the inputs held across it.
    task automatic tick();
        bit acc;
        acc = exp_req() && imem_ready;
        @(posedge clk);
        if (acc) begin
            if (pc_src == 2'd3 && reg_target[1:0] != 2'b00) m_mis = 1'b1;
            m_pc = ref_next(m_pc, pc_src, branch_offset, jump_shifted, reg_target);
            if (halt) m_halted = 1'b1;
        end
        m_edges++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(2'd0, 1'b0, 1'b1, 1'b0);
        jump_shifted  = '0;
        branch_offset = '0;
        reg_target    = '0;
        @(negedge clk);
        rst      = 1'b0;
        m_pc     = RST_PC;
        m_edges  = 0;
        m_halted = 1'b0;
        m_mis    = 1'b0;
    endtask

    task automatic boot();
        drive(2'd0, 1'b0, 1'b1, 1'b0);
        repeat (BOOT + 1) tick();
    endtask

    task automatic set_pc(input logic [31:0] value);
        drive(2'd3, 1'b0, 1'b1, 1'b0);
        reg_target = value;
        tick();
        drive(2'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        boot();
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL reset_async_pc: got %h expected %h", pc, RST_PC); end
        n_checks++; if (pc_plus4 !== RST_PC + 32'd4) begin n_fail++; $display("FAIL reset_pc_plus4: got %h expected %h", pc_plus4, RST_PC + 32'd4); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req: got %b expected 0", imem_req); end
        n_checks++; if (halted !== 1'b0 || misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got halted=%b mis=%b expected 0 0", halted, misalign_err); end
        @(posedge clk); #1;
        n_checks++; if (pc !== RST_PC || pc_plus4 !== RST_PC + 32'd4 || imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_held: got pc=%h pc4=%h req=%b expected %h %h 0", pc, pc_plus4, imem_req, RST_PC, RST_PC + 32'd4); end
        @(negedge clk);
        rst      = 1'b0;
        m_pc     = RST_PC;
        m_edges  = 0;
        m_halted = 1'b0;
        m_mis    = 1'b0;
    endtask

    task automatic test_boot_seq();
        logic        req_tbl [1:5];
        logic [31:0] pc_tbl  [1:5];
        req_tbl = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        pc_tbl  = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8};
        do_reset();
        drive(2'd0, 1'b0, 1'b1, 1'b0);
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL boot_req_e0: got %b expected 0", imem_req); end
        for (int e = 1; e <= 5; e++) begin
            tick();
            n_checks++; if (imem_req !== req_tbl[e]) begin n_fail++; $display("FAIL boot_req_e%0d: got %b expected %b", e, imem_req, req_tbl[e]); end
            n_checks++; if (pc !== pc_tbl[e]) begin n_fail++; $display("FAIL boot_pc_e%0d: got %h expected %h", e, pc, pc_tbl[e]); end
        end
    endtask

    task automatic test_jump();
        do_reset();
        boot();
        set_pc(32'h1000_0010);
        n_checks++; if (pc !== 32'h1000_0010) begin n_fail++; $display("FAIL jump_setup_pc: got %h expected %h", pc, 32'h1000_0010); end
        drive(2'd2, 1'b0, 1'b1, 1'b0);
        jump_shifted = 28'h0ABC_DE4;
        tick();
        n_checks++; if (pc !== 32'h10AB_CDE4) begin n_fail++; $display("FAIL jump_pc: got %h expected %h", pc, 32'h10AB_CDE4); end
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL jump_mis: got %b expected 0", misalign_err); end
    endtask

    task automatic test_branch_wrap();
        set_pc(32'h0000_0040);
        drive(2'd1, 1'b0, 1'b1, 1'b0);
        branch_offset = 32'hFFFF_FFF0;
        tick();
        n_checks++; if (pc !== 32'h0000_0034) begin n_fail++; $display("FAIL branch_back_pc: got %h expected %h", pc, 32'h34); end
        set_pc(32'hFFFF_FFFC);
        n_checks++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_plus4: got %h expected 0", pc_plus4); end
        drive(2'd0, 1'b0, 1'b1, 1'b0);
        tick();
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h expected 0", pc); end
    endtask

    task automatic test_stall();
        set_pc(32'h0000_0100);
        // Halt and a misaligned register target under stall must be ignored.
        drive(2'd3, 1'b1, 1'b1, 1'b1);
        reg_target = 32'h0000_0055;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_c%0d: got %b expected 0", c, imem_req); end
            tick();
            n_checks++; if (pc !== 32'h100 || halted !== 1'b0) begin n_fail++; $display("FAIL stall_hold_c%0d: got pc=%h halted=%b expected 100 0", c, pc, halted); end
        end
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL stall_mis: got %b expected 0", misalign_err); end
        drive(2'd0, 1'b0, 1'b1, 1'b0);
        #1;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_release_req: got %b expected 1", imem_req); end
        tick();
        n_checks++; if (pc !== 32'h104) begin n_fail++; $display("FAIL stall_release_pc: got %h expected 104", pc); end
    endtask

    task automatic test_misalign();
        drive(2'd3, 1'b0, 1'b1, 1'b0);
        reg_target = 32'h0000_0203;
        tick();
        n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL misalign_pc: got %h expected 200", pc); end
        n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_set: got %b expected 1", misalign_err); end
        drive(2'd0, 1'b0, 1'b0, 1'b0);
        reg_target = 32'h0;
        repeat (10) tick();
        n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL not_ready_hold: got %h expected 200", pc); end
        n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_sticky: got %b expected 1", misalign_err); end
    endtask

    task automatic test_halt();
        do_reset();
        boot();
        set_pc(32'h0000_0008);
        drive(2'd0, 1'b0, 1'b1, 1'b1);
        tick();
        n_checks++; if (pc !== 32'hC || halted !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_entry: got pc=%h halted=%b req=%b expected c 1 0", pc, halted, imem_req); end
        for (int c = 0; c < 5; c++) begin
            drive(2'($urandom_range(0, 3)), 1'b0, 1'b1, 1'($urandom_range(0, 1)));
            reg_target = $urandom;
            tick();
        end
        n_checks++; if (pc !== 32'hC || halted !== 1'b1 || imem_req !== 1'b0 || misalign_err !== 1'b0) begin n_fail++; $display("FAIL halt_hold: got pc=%h halted=%b req=%b mis=%b expected c 1 0 0", pc, halted, imem_req, misalign_err); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (pc !== RST_PC || halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset: got pc=%h halted=%b expected %h 0", pc, halted, RST_PC); end
        @(negedge clk);
        rst      = 1'b0;
        m_pc     = RST_PC;
        m_edges  = 0;
        m_halted = 1'b0;
        m_mis    = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
            branch_offset = $urandom;
            jump_shifted  = 28'($urandom);
            reg_target    = $urandom;
            if ($urandom_range(0, 9) != 0) reg_target[1:0] = 2'b00;
            #1;
            n_checks++; if (imem_req !== exp_req()) begin n_fail++; $display("FAIL rand_req_%0d: got %b expected %b", i, imem_req, exp_req()); end
            tick();
            n_checks++; if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4) begin n_fail++; $display("FAIL rand_pc_%0d: got pc=%h pc4=%h expected %h %h", i, pc, pc_plus4, m_pc, m_pc + 32'd4); end
            n_checks++; if (halted !== m_halted || misalign_err !== m_mis) begin n_fail++; $display("FAIL rand_flags_%0d: got halted=%b mis=%b expected %b %b", i, halted, misalign_err, m_halted, m_mis); end
            if (m_halted && $urandom_range(0, 7) == 0) do_reset();
        end
    endtask

    initial begin
        rst           = 1'b1;
        jump_shifted  = '0;
        branch_offset = '0;
        reg_target    = '0;
        drive(2'd0, 1'b0, 1'b0, 1'b0);
        m_pc     = RST_PC;
        m_edges  = 0;
        m_halted = 1'b0;
        m_mis    = 1'b0;

        test_reset();
        test_boot_seq();
        test_jump();
        test_branch_wrap();
        test_stall();
        test_misalign();
        test_halt();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire
